// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer. Channel selection is either manual (from s)
// or automatic round-robin with a programmable dwell per channel.
module mux_scan #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned NCH   = 8,
  parameter int unsigned SELW  = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SELW-1:0]        s,
  input  logic [NCH*WIDTH-1:0]   a,
  output logic [WIDTH-1:0]       y,
  output logic [SELW-1:0]        ch,
  output logic                   valid,
  output logic                   wrap
);

  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);

  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_n;
  logic [WIDTH-1:0] y_n;
  logic [SELW-1:0]  ch_n;
  logic             valid_n;
  logic             wrap_n;

  // Channel data for idx; zero when idx names no physical channel.
  function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] idx,
                                            input logic [NCH*WIDTH-1:0] d);
    pick = '0;
    for (int k = 0; k < NCH; k++)
      if (idx == SELW'(k)) pick = d[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic in_range(input logic [SELW-1:0] idx);
    in_range = 1'b0;
    for (int k = 0; k < NCH; k++)
      if (idx == SELW'(k)) in_range = 1'b1;
  endfunction

  // Next-state: manual select or dwell-counted round-robin; y always follows next ch.
  always_comb begin
    y_n     = y;
    ch_n    = ch;
    valid_n = valid;
    cnt_n   = cnt;
    wrap_n  = 1'b0;
    if (en) begin
      if (!mode) begin
        ch_n    = s;
        cnt_n   = '0;
        valid_n = in_range(s);
      end else begin
        valid_n = 1'b1;
        if (!in_range(ch)) begin
          ch_n  = '0;
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (ch == CH_LAST) begin
            ch_n   = '0;
            wrap_n = 1'b1;
          end else begin
            ch_n = ch + SELW'(1);
          end
        end else begin
          cnt_n = cnt + CNTW'(1);
        end
      end
      y_n = pick(ch_n, a);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else begin
      y     <= y_n;
      ch    <= ch_n;
      valid <= valid_n;
      wrap  <= wrap_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: the driver pushes expected post-edge outputs from a
// position-based reference model; a monitor pops and compares after every rising edge.
module tb_mux_scan;
  localparam int WIDTH = 4;
  localparam int NCH   = 6;
  localparam int SELW  = 3;
  localparam int DWELL = 4;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [SELW-1:0]  ch;
    logic             valid;
    logic             wrap;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 mode = 1'b0;
  logic [SELW-1:0]      s = '0;
  logic [NCH*WIDTH-1:0] a = '0;
  logic [WIDTH-1:0]     y;
  logic [SELW-1:0]      ch;
  logic                 valid;
  logic                 wrap;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  // Reference model state: channel, cycles already spent on it, and outputs.
  int chan [NCH];
  int m_ch = 0, m_phase = 0, m_y = 0, m_valid = 0, m_wrap = 0;

  mux_scan #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .a(a),
    .y(y), .ch(ch), .valid(valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the oldest expected entry after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_y",     int'(y),     int'(e.y));
        check("sb_ch",    int'(ch),    int'(e.ch));
        check("sb_valid", int'(valid), int'(e.valid));
        check("sb_wrap",  int'(wrap),  int'(e.wrap));
      end
    end
  end

  function automatic void model_edge(input bit r, input bit e_, input bit md, input int sel);
    int pos;
    if (r) begin
      m_ch = 0; m_phase = 0; m_y = 0; m_valid = 0; m_wrap = 0;
      return;
    end
    m_wrap = 0;
    if (!e_) return;
    if (!md) begin
      m_ch = sel;
      m_phase = 0;
      m_valid = (sel < NCH) ? 1 : 0;
    end else begin
      m_valid = 1;
      if (m_ch >= NCH) begin
        m_ch = 0;
        m_phase = 0;
      end else begin
        // Linear position through the whole scan cycle, modulo its length.
        pos = (m_ch * DWELL + m_phase + 1) % (NCH * DWELL);
        m_wrap = (pos == 0) ? 1 : 0;
        m_ch = pos / DWELL;
        m_phase = pos % DWELL;
      end
    end
    m_y = (m_ch < NCH) ? chan[m_ch] : 0;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected response.
  task automatic step(input bit r, input bit e_, input bit md, input int sel);
    exp_t ex;
    @(negedge clk);
    for (int k = 0; k < NCH; k++) a[k*WIDTH +: WIDTH] = WIDTH'(chan[k]);
    rst = r; en = e_; mode = md; s = SELW'(sel);
    model_edge(r, e_, md, sel);
    ex.y = WIDTH'(m_y); ex.ch = SELW'(m_ch); ex.valid = m_valid[0]; ex.wrap = m_wrap[0];
    q.push_back(ex);
    if (r) begin
      #1;
      check("async_rst_y",     int'(y),     0);
      check("async_rst_ch",    int'(ch),    0);
      check("async_rst_valid", int'(valid), 0);
      check("async_rst_wrap",  int'(wrap),  0);
    end
  endtask

  task automatic rand_chan();
    for (int k = 0; k < NCH; k++) chan[k] = int'($urandom_range(0, 15));
  endtask

  task automatic expect_now(input string name, input int exp_ch);
    @(posedge clk);
    #2;
    check(name, int'(ch), exp_ch);
  endtask

  initial begin
    bit md;
    for (int k = 0; k < NCH; k++) chan[k] = 0;
    a = NCH*WIDTH'($urandom);
    s = SELW'($urandom);
    #1;
    check("init_rst_y",     int'(y),     0);
    check("init_rst_ch",    int'(ch),    0);
    check("init_rst_valid", int'(valid), 0);
    check("init_rst_wrap",  int'(wrap),  0);
    rand_chan();
    repeat (2) step(1, 1, 0, int'($urandom_range(0, 7)));

    // First manual select: channel 3 holds 1.
    for (int k = 0; k < NCH; k++) chan[k] = 0;
    chan[3] = 1;
    step(0, 1, 0, 3);

    // Manual sweep with channel k holding k, including out-of-range selects.
    for (int k = 0; k < NCH; k++) chan[k] = k;
    for (int i = 0; i < 8; i++) step(0, 1, 0, i);

    // Scan from reset for 40 cycles with occasional live data changes.
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) rand_chan();
      step(0, 1, 1, 0);
    end

    // Enable hold at ch=2, cnt=1, then resume the dwell.
    step(1, 0, 0, 0);
    for (int i = 0; i < 2*DWELL + 1; i++) step(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      rand_chan();
      step(0, 0, 1, 0);
    end
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    expect_now("hold_resume_ch2", 2);
    step(0, 1, 1, 0);
    expect_now("hold_resume_ch3", 3);

    // Out-of-range manual select, then switch to scan.
    rand_chan();
    step(0, 1, 0, 7);
    expect_now("oor_ch7", 7);
    step(0, 1, 1, 0);
    expect_now("oor_scan_ch0", 0);

    // Async reset mid-scan at ch=5, then a full dwell from channel 0.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5*DWELL; i++) step(0, 1, 1, 0);
    expect_now("pre_rst_ch5", 5);
    step(1, 1, 1, 0);
    for (int i = 0; i < DWELL + 2; i++) step(0, 1, 1, 0);

    // Random traffic with sticky mode.
    md = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) md = ~md;
      if ($urandom_range(0, 3) == 0) rand_chan();
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0), md,
           int'($urandom_range(0, 7)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
